// File: rtl/checker_renderer.sv
// 640x480 VGA renderer for an 8x8 checkers board. Inputs are snapshotted at the
// start of vertical blank so each frame is drawn from one consistent board state.
module checker_renderer #(
    parameter int BOARD_X0 = 80,
    parameter int SQ       = 60
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [191:0] serialized_board,
    input  logic [27:0]  legal_move,
    input  logic [5:0]   cursor_loc,
    output logic [7:0]   vga_r,
    output logic [7:0]   vga_g,
    output logic [7:0]   vga_b,
    output logic         hsync,
    output logic         vsync,
    output logic         blank_n,
    output logic         frame_start
);

    localparam logic [9:0] H_LAST    = 10'd799;
    localparam logic [9:0] V_LAST    = 10'd524;
    localparam logic [9:0] H_VIS     = 10'd640;
    localparam logic [9:0] V_VIS     = 10'd480;
    localparam logic [9:0] HS_START  = 10'd656;
    localparam logic [9:0] HS_END    = 10'd751;
    localparam logic [9:0] VS_START  = 10'd490;
    localparam logic [9:0] VS_END    = 10'd491;
    localparam logic [9:0] SNAP_V    = 10'd480;
    localparam logic [9:0] X_LO      = 10'(BOARD_X0);
    localparam logic [9:0] X_HI      = 10'(BOARD_X0 + 8 * SQ);
    localparam logic [9:0] Y_HI      = 10'(8 * SQ);
    localparam logic [5:0] SQ_LAST   = 6'(SQ - 1);
    localparam logic [5:0] BORDER_HI = 6'(SQ - 4);

    logic [9:0]   r_hCnt, r_vCnt;
    logic [5:0]   r_dx, r_dy;
    logic [2:0]   r_col, r_row;
    logic [191:0] r_snapBoard;
    logic [27:0]  r_snapLegal;
    logic [5:0]   r_snapCursor;
    logic [5:0]   r_loc1, r_dx1, r_dy1;
    logic [2:0]   r_cell1;
    logic         r_legal1, r_cursor1, r_active1;
    logic [23:0]  r_rgb;
    logic [1:0]   r_hsPipe, r_vsPipe, r_blPipe;

    logic              w_hLast, w_vLast, w_snap, w_legal, w_cursor, w_active;
    logic [9:0]        w_hNext, w_vNext;
    logic [5:0]        w_loc;
    logic [7:0]        w_cellBase;
    logic [2:0]        w_cell;
    logic signed [6:0] w_offX, w_offY;
    logic signed [11:0] w_offXW, w_offYW;
    logic [11:0]       w_sqX, w_sqY, w_distSq;
    logic              w_king, w_disc, w_border, w_dark;
    logic [23:0]       w_rgb;

    assign w_hLast = (r_hCnt == H_LAST);
    assign w_vLast = (r_vCnt == V_LAST);
    assign w_hNext = w_hLast ? 10'd0 : r_hCnt + 10'd1;
    assign w_vNext = w_vLast ? 10'd0 : r_vCnt + 10'd1;
    assign w_snap  = (r_hCnt == 10'd0) && (r_vCnt == SNAP_V);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hCnt <= 10'd0;
            r_vCnt <= 10'd0;
        end else begin
            r_hCnt <= w_hNext;
            if (w_hLast) r_vCnt <= w_vNext;
        end
    end

    // Square column/row and in-square offsets track the raster counters, so
    // they are restarted at the board's left edge and at the top of each frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dx  <= 6'd0;
            r_col <= 3'd0;
            r_dy  <= 6'd0;
            r_row <= 3'd0;
        end else begin
            if (w_hNext == X_LO) begin
                r_dx  <= 6'd0;
                r_col <= 3'd0;
            end else if (r_dx == SQ_LAST) begin
                r_dx  <= 6'd0;
                r_col <= r_col + 3'd1;
            end else begin
                r_dx <= r_dx + 6'd1;
            end
            if (w_hLast) begin
                if (w_vNext == 10'd0) begin
                    r_dy  <= 6'd0;
                    r_row <= 3'd0;
                end else if (r_dy == SQ_LAST) begin
                    r_dy  <= 6'd0;
                    r_row <= r_row + 3'd1;
                end else begin
                    r_dy <= r_dy + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snapBoard  <= '0;
            r_snapLegal  <= '0;
            r_snapCursor <= '0;
        end else if (w_snap) begin
            r_snapBoard  <= serialized_board;
            r_snapLegal  <= legal_move;
            r_snapCursor <= cursor_loc;
        end
    end

    assign frame_start = w_snap;

    assign w_loc      = {r_col, 3'd7 - r_row};
    assign w_cellBase = {2'b00, w_loc} * 8'd3;
    assign w_cell     = r_snapBoard[w_cellBase +: 3];
    assign w_cursor   = (w_loc == r_snapCursor);
    assign w_active   = (r_hCnt < H_VIS) && (r_vCnt < V_VIS) &&
                        (r_hCnt >= X_LO) && (r_hCnt < X_HI) && (r_vCnt < Y_HI);

    always_comb begin
        w_legal = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (r_snapLegal[7*k+6] && (r_snapLegal[7*k +: 6] == w_loc)) w_legal = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_loc1    <= 6'd0;
            r_dx1     <= 6'd0;
            r_dy1     <= 6'd0;
            r_cell1   <= 3'd0;
            r_legal1  <= 1'b0;
            r_cursor1 <= 1'b0;
            r_active1 <= 1'b0;
        end else begin
            r_loc1    <= w_loc;
            r_dx1     <= r_dx;
            r_dy1     <= r_dy;
            r_cell1   <= w_cell;
            r_legal1  <= w_legal;
            r_cursor1 <= w_cursor;
            r_active1 <= w_active;
        end
    end

    // Disc geometry is centred at offset 30; squares of signed offsets are
    // formed at 12 bits so the sum can never wrap.
    assign w_offX   = $signed({1'b0, r_dx1}) - 7'sd30;
    assign w_offY   = $signed({1'b0, r_dy1}) - 7'sd30;
    assign w_offXW  = {{5{w_offX[6]}}, w_offX};
    assign w_offYW  = {{5{w_offY[6]}}, w_offY};
    assign w_sqX    = w_offXW * w_offXW;
    assign w_sqY    = w_offYW * w_offYW;
    assign w_distSq = w_sqX + w_sqY;
    assign w_king   = (w_distSq < 12'd100);
    assign w_disc   = (w_distSq < 12'd484);
    assign w_border = (r_dx1 < 6'd3) || (r_dx1 > BORDER_HI) ||
                      (r_dy1 < 6'd3) || (r_dy1 > BORDER_HI);
    assign w_dark   = (((r_loc1[5:3] + r_loc1[2:0]) & 3'd1) == 3'd0);

    always_comb begin
        w_rgb = 24'h000000;
        if (!r_active1)                                w_rgb = 24'h000000;
        else if (r_cursor1 && w_border)                w_rgb = 24'hFFFF00;
        else if (r_cell1[2] && r_cell1[0] && w_king)   w_rgb = 24'hFFD700;
        else if (r_cell1[2] && w_disc)                 w_rgb = r_cell1[1] ? 24'hE02020 : 24'hF0F0F0;
        else if (r_legal1)                             w_rgb = 24'h2060C0;
        else if (w_dark)                               w_rgb = 24'h206020;
        else                                           w_rgb = 24'hE0D0B0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rgb    <= 24'h000000;
            r_hsPipe <= 2'b11;
            r_vsPipe <= 2'b11;
            r_blPipe <= 2'b00;
        end else begin
            r_rgb    <= w_rgb;
            r_hsPipe <= {r_hsPipe[0], !((r_hCnt >= HS_START) && (r_hCnt <= HS_END))};
            r_vsPipe <= {r_vsPipe[0], !((r_vCnt >= VS_START) && (r_vCnt <= VS_END))};
            r_blPipe <= {r_blPipe[0], (r_hCnt < H_VIS) && (r_vCnt < V_VIS)};
        end
    end

    assign vga_r   = r_rgb[23:16];
    assign vga_g   = r_rgb[15:8];
    assign vga_b   = r_rgb[7:0];
    assign hsync   = r_hsPipe[1];
    assign vsync   = r_vsPipe[1];
    assign blank_n = r_blPipe[1];

endmodule

// File: tb/tb_checker_renderer.sv
// Self-checking bench for checker_renderer: pixel expectations go into a
// scoreboard tagged by frame and are compared when that pixel reaches the outputs.
module tb_checker_renderer;

    logic         clk;
    logic         rst;
    logic [191:0] serialized_board;
    logic [27:0]  legal_move;
    logic [5:0]   cursor_loc;
    logic [7:0]   vga_r, vga_g, vga_b;
    logic         hsync, vsync, blank_n, frame_start;

    checker_renderer #(.BOARD_X0(80), .SQ(60)) dut (
        .clk(clk), .rst(rst),
        .serialized_board(serialized_board), .legal_move(legal_move), .cursor_loc(cursor_loc),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        int          h;
        int          v;
        int          frame;
        logic [23:0] rgb;
        string       name;
    } pixVec_t;

    pixVec_t frame1Vecs[$];
    pixVec_t frame2Vecs[$];
    pixVec_t sbQueue[$];

    int checks = 0;
    int passes = 0;

    int tbH, tbV, tbFrame;
    logic syncOn = 1'b0;
    logic prevSyncOn = 1'b0;
    logic prevHs;
    int hsRun, hsPulses, hsBad, vsLow, vsPulses, blHigh, fsCount, fsBad;
    logic prevVs;

    // Reference raster timing: the pixel counter the DUT should be at.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tbH <= 0;
            tbV <= 0;
            tbFrame <= 0;
        end else begin
            if (tbH == 0 && tbV == 480) tbFrame <= tbFrame + 1;
            if (tbH == 799) begin
                tbH <= 0;
                tbV <= (tbV == 524) ? 0 : tbV + 1;
            end else begin
                tbH <= tbH + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    function automatic pixVec_t mkVec(input int h, input int v, input logic [23:0] rgb, input string name);
        pixVec_t p;
        p.h = h; p.v = v; p.frame = 0; p.rgb = rgb; p.name = name;
        return p;
    endfunction

    function automatic logic [191:0] putCell(input logic [191:0] b, input int x, input int y, input logic [2:0] c);
        logic [191:0] r;
        r = b;
        r[3*(x*8+y) +: 3] = c;
        return r;
    endfunction

    // Drives the board inputs and queues the pixels expected in the given frame.
    task automatic applyStimulus(input logic [191:0] board, input logic [27:0] legal,
                                 input logic [5:0] cursor, input int frame);
        pixVec_t p;
        serialized_board = board;
        legal_move       = legal;
        cursor_loc       = cursor;
        if (frame == 1) begin
            foreach (frame1Vecs[k]) begin p = frame1Vecs[k]; p.frame = frame; sbQueue.push_back(p); end
        end else begin
            foreach (frame2Vecs[k]) begin p = frame2Vecs[k]; p.frame = frame; sbQueue.push_back(p); end
        end
    endtask

    task automatic waitPixel(input int h, input int v, input string what);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tbH == h && tbV == v) && n < 900000);
        if (n >= 900000) begin
            checks++;
            $display("[TB] FAIL timeout %s: got no pixel (%0d,%0d), expected it within 900000 cycles", what, h, v);
        end
    endtask

    // Output monitor: scoreboard matching plus sync statistics over a frame window.
    always @(negedge clk) begin : monitor
        int idx, ph, pv;
        if (rst) begin
            idx = tbV * 800 + tbH - 2;
            if (idx < 0) idx += 420000;
            ph = idx % 800;
            pv = idx / 800;
            for (int k = 0; k < sbQueue.size(); k++) begin
                if (sbQueue[k].h == ph && sbQueue[k].v == pv && sbQueue[k].frame == tbFrame) begin
                    checkOutput(sbQueue[k].name, {8'h00, vga_r, vga_g, vga_b}, {8'h00, sbQueue[k].rgb});
                    sbQueue.delete(k);
                    break;
                end
            end
            if (syncOn && !prevSyncOn) begin
                hsRun = 0; hsPulses = 0; hsBad = 0; vsLow = 0; vsPulses = 0;
                blHigh = 0; fsCount = 0; fsBad = 0; prevHs = 1'b1; prevVs = 1'b1;
            end
            if (syncOn) begin
                if (!hsync) hsRun++;
                else if (!prevHs) begin
                    hsPulses++;
                    if (hsRun != 96) hsBad++;
                    hsRun = 0;
                end
                if (!vsync) vsLow++;
                if (!vsync && prevVs) vsPulses++;
                if (blank_n) blHigh++;
                if (frame_start) begin
                    fsCount++;
                    if (!(tbH == 0 && tbV == 480)) fsBad++;
                end
                prevHs = hsync;
                prevVs = vsync;
            end
            prevSyncOn = syncOn;
        end
    end

    logic [191:0] boardA, boardB;
    logic [27:0]  legalA, legalB;

    initial begin
        frame1Vecs.push_back(mkVec(100,  10, 24'hE0D0B0, "light square 0,7"));
        frame1Vecs.push_back(mkVec(470,  90, 24'hFFD700, "king centre 6,6"));
        frame1Vecs.push_back(mkVec(479,  90, 24'hFFD700, "king inner edge"));
        frame1Vecs.push_back(mkVec(480,  90, 24'hE02020, "king ring start"));
        frame1Vecs.push_back(mkVec(485,  90, 24'hE02020, "king ring +15"));
        frame1Vecs.push_back(mkVec( 79,  90, 24'h000000, "left of board"));
        frame1Vecs.push_back(mkVec(559,  90, 24'hE0D0B0, "last board column"));
        frame1Vecs.push_back(mkVec(560,  90, 24'h000000, "right of board"));
        frame1Vecs.push_back(mkVec(290, 120, 24'hFFFF00, "cursor top border"));
        frame1Vecs.push_back(mkVec(260, 150, 24'hFFFF00, "cursor left dx0"));
        frame1Vecs.push_back(mkVec(262, 150, 24'hFFFF00, "cursor left dx2"));
        frame1Vecs.push_back(mkVec(263, 150, 24'h206020, "cursor inside dx3"));
        frame1Vecs.push_back(mkVec(290, 150, 24'hE02020, "cursor piece centre"));
        frame1Vecs.push_back(mkVec(316, 150, 24'h206020, "cursor inside dx56"));
        frame1Vecs.push_back(mkVec(319, 150, 24'hFFFF00, "cursor right dx59"));
        frame1Vecs.push_back(mkVec(410, 160, 24'h2060C0, "legal field3 5,5"));
        frame1Vecs.push_back(mkVec(350, 210, 24'h206020, "unoccupied red king bits"));
        frame1Vecs.push_back(mkVec(230, 330, 24'h2060C0, "legal 2,2 duplicate"));
        frame1Vecs.push_back(mkVec(142, 362, 24'h206020, "white square corner"));
        frame1Vecs.push_back(mkVec(148, 390, 24'h206020, "disc left outside"));
        frame1Vecs.push_back(mkVec(149, 390, 24'hF0F0F0, "disc left inside"));
        frame1Vecs.push_back(mkVec(170, 390, 24'hF0F0F0, "white disc centre"));
        frame1Vecs.push_back(mkVec(191, 390, 24'hF0F0F0, "disc right inside"));
        frame1Vecs.push_back(mkVec(192, 390, 24'h206020, "disc right outside"));
        frame1Vecs.push_back(mkVec(530, 450, 24'hE0D0B0, "invalid legal field 7,0"));
        frame1Vecs.push_back(mkVec(600, 470, 24'h000000, "visible off board"));

        frame2Vecs.push_back(mkVec(470,  90, 24'hFFD700, "f2 king centre"));
        frame2Vecs.push_back(mkVec(260, 150, 24'h206020, "f2 old cursor gone"));
        frame2Vecs.push_back(mkVec(290, 150, 24'hE02020, "f2 piece 3,5"));
        frame2Vecs.push_back(mkVec(410, 160, 24'h2060C0, "f2 legal field3"));
        frame2Vecs.push_back(mkVec(230, 330, 24'h206020, "f2 legal invalidated"));
        frame2Vecs.push_back(mkVec(170, 390, 24'hE02020, "f2 piece now red"));
        frame2Vecs.push_back(mkVec( 80, 450, 24'hFFFF00, "f2 new cursor 0,0"));
        frame2Vecs.push_back(mkVec(110, 450, 24'h206020, "f2 cursor interior"));

        boardA = '0;
        boardA = putCell(boardA, 1, 1, 3'b100);
        boardA = putCell(boardA, 6, 6, 3'b111);
        boardA = putCell(boardA, 3, 5, 3'b110);
        boardA = putCell(boardA, 4, 4, 3'b011);
        boardB = putCell(boardA, 1, 1, 3'b110);
        legalA = {7'h6D, 7'h38, 7'h52, 7'h52};
        legalB = {7'h6D, 7'h38, 7'h12, 7'h12};

        rst = 1'b0;
        applyStimulus(boardA, legalA, 6'o35, 1);
        repeat (4) @(negedge clk);
        checkOutput("reset rgb", {8'h00, vga_r, vga_g, vga_b}, 32'h0);
        checkOutput("reset blank_n", {31'h0, blank_n}, 32'h0);
        checkOutput("reset hsync", {31'h0, hsync}, 32'h1);
        checkOutput("reset vsync", {31'h0, vsync}, 32'h1);
        checkOutput("reset frame_start", {31'h0, frame_start}, 32'h0);
        rst = 1'b1;

        waitPixel(1, 480, "first snapshot");
        syncOn = 1'b1;
        waitPixel(0, 200, "mid frame 1");
        applyStimulus(boardB, legalB, 6'o00, 2);
        waitPixel(1, 480, "second snapshot");
        syncOn = 1'b0;
        checkOutput("hsync pulses per frame", hsPulses, 525);
        checkOutput("hsync pulse width errors", hsBad, 0);
        checkOutput("vsync low cycles", vsLow, 1600);
        checkOutput("vsync pulses", vsPulses, 1);
        checkOutput("blank_n high cycles", blHigh, 307200);
        checkOutput("frame_start pulses", fsCount, 1);
        checkOutput("frame_start position errors", fsBad, 0);

        waitPixel(1, 480, "third snapshot");
        checkOutput("scoreboard leftovers", sbQueue.size(), 0);

        waitPixel(300, 100, "pre-reset pixel");
        checkOutput("pre-reset pixel", {8'h00, vga_r, vga_g, vga_b}, 32'h00E0D0B0);
        checkOutput("pre-reset blank_n", {31'h0, blank_n}, 32'h1);
        #5 rst = 1'b0;
        #1;
        checkOutput("async reset rgb", {8'h00, vga_r, vga_g, vga_b}, 32'h0);
        checkOutput("async reset blank_n", {31'h0, blank_n}, 32'h0);
        checkOutput("async reset hsync", {31'h0, hsync}, 32'h1);
        checkOutput("async reset frame_start", {31'h0, frame_start}, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/checker_renderer.md
CHECKER_RENDERER -- requirements
Module: checker_renderer

Interface
REQ-001 SHALL have parameter BOARD_X0, default 80, giving the left pixel column of the board area.
REQ-002 SHALL have parameter SQ, default 60, giving the square edge length in pixels.
REQ-003 SHALL have input clk, 1 bit: pixel clock, 25.175 MHz nominal, rising-edge.
REQ-004 SHALL have input rst, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have input serialized_board, 192 bits: cell i at bits [3i+2:3i], i = {x[2:0], y[2:0]}; bit2 = occupied, bit1 = red, bit0 = king.
REQ-006 SHALL have input legal_move, 28 bits: four 7-bit fields [6:0], [13:7], [20:14], [27:21]; field bit6 = valid, bits5:0 = location {x, y}.
REQ-007 SHALL have input cursor_loc, 6 bits: cursor square {x, y}.
REQ-008 SHALL have outputs vga_r, vga_g, vga_b, 8 bits each: pixel colour.
REQ-009 SHALL have outputs hsync, vsync, blank_n, 1 bit each; hsync and vsync are active-low, blank_n is high in the visible area.
REQ-010 SHALL have output frame_start, 1 bit: one-cycle pulse when a new snapshot is taken.

Function
REQ-011 SHALL run h_cnt 0..799 (wraps to 0), and SHALL increment v_cnt 0..524 (wraps to 0) when h_cnt wraps.
REQ-012 SHALL treat the visible area as h_cnt<640 and v_cnt<480; hsync low for h_cnt 656..751; vsync low for v_cnt 490..491.
REQ-013 SHALL snapshot serialized_board, legal_move and cursor_loc in the cycle where h_cnt==0 and v_cnt==480, pulse frame_start in that same cycle, and render the whole next frame from the snapshot only (no tearing).
REQ-014 SHALL define the board area as BOARD_X0 <= h_cnt < BOARD_X0+8*SQ and v_cnt < 8*SQ.
REQ-015 SHALL map board pixels to col = (h_cnt-BOARD_X0)/SQ, row = v_cnt/SQ, and square loc = {col, 7-row}, so y=7 is the top row.
REQ-016 SHALL derive col, row and in-square offsets dx, dy (0..SQ-1) from auxiliary counters, with no divider.
REQ-017 SHALL use a 2-stage pipeline: stage 1 registers loc, dx, dy, the cell, the legal flag and the cursor flag; stage 2 registers the colour.
REQ-018 SHALL delay hsync, vsync and blank_n by 2 cycles so they stay aligned with the colour outputs.
REQ-019 SHALL set the legal flag when any snapshot field has valid==1 and location==loc; duplicate fields are harmless.
REQ-020 SHALL define a dark square as (x+y) even and a light square as (x+y) odd.
REQ-021 SHALL compute colour with this priority, highest first:
  (a) outside the board or blank -> 000000
  (b) cursor square and (dx<3 or dx>SQ-4 or dy<3 or dy>SQ-4) -> FFFF00
  (c) occupied, king, and (dx-30)^2+(dy-30)^2 < 100 -> FFD700
  (d) occupied and (dx-30)^2+(dy-30)^2 < 484 -> E02020 if red, else F0F0F0
  (e) legal flag -> 2060C0
  (f) dark square -> 206020; light square -> E0D0B0
REQ-022 SHALL compute the disc test with signed 7-bit offsets and unsigned 12-bit squared sums, with no truncation.
REQ-023 SHALL ignore occupied==0 cells regardless of their red and king bits.
REQ-024 SHALL treat input changes outside the snapshot cycle as having no effect until the next snapshot.

Reset
REQ-025 While rst is low, SHALL hold h_cnt=0, v_cnt=0, all pipeline registers and snapshots at 0, vga_r/g/b=0, blank_n=0, hsync=1, vsync=1, frame_start=0.
REQ-026 On reset release, SHALL count from h_cnt=0, v_cnt=0 with the empty snapshot; the first real snapshot is taken at v_cnt=480.
REQ-027 On reset asserted mid-frame, SHALL force all outputs to their reset values immediately, without waiting for a clock edge.

Verification
REQ-028 Reset, then 800*525 cycles -> exactly one 96-cycle hsync pulse per line, one 2-line vsync pulse per frame, frame_start exactly once per frame.
REQ-029 Board cell {1,1} = 100, pixel h=80+60+30, v=6*60+30 -> output 2 cycles later = F0F0F0; pixel h=80+60+2, v=6*60+2 -> 206020.
REQ-030 Cell {6,6} = 111 -> square centre = FFD700; centre offset (+15, 0) -> E02020; pixel h=79 -> 000000.
REQ-031 legal_move[6:0] = {1, 2, 2}, cell {2,2} empty -> square {2,2} interior = 2060C0; the same field with valid=0 -> 206020.
REQ-032 cursor_loc = {3,5} with a piece present -> square border 3 pixels wide = FFFF00, interior piece colour unchanged.
REQ-033 Change serialized_board mid-frame -> visible output unchanged until the frame after the next frame_start.
